// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared mode/select encodings and the flag bundle for the
//               pipelined ALU (alu_core, alu_pipe).
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

   localparam logic MODE_ARITH = 1'b0;
   localparam logic MODE_LOGIC = 1'b1;

   // Arithmetic functions: result = X + Y + cin
   localparam logic [3:0] SEL_INC_A                = 4'd0;
   localparam logic [3:0] SEL_INC_A_OR_B           = 4'd1;
   localparam logic [3:0] SEL_INC_A_OR_NB          = 4'd2;
   localparam logic [3:0] SEL_MINUS_ONE            = 4'd3;
   localparam logic [3:0] SEL_A_PLUS_A_AND_NB      = 4'd4;
   localparam logic [3:0] SEL_A_OR_B_PLUS_A_AND_NB = 4'd5;
   localparam logic [3:0] SEL_A_MINUS_B            = 4'd6;
   localparam logic [3:0] SEL_A_AND_NB_MINUS_ONE   = 4'd7;
   localparam logic [3:0] SEL_A_PLUS_A_AND_B       = 4'd8;
   localparam logic [3:0] SEL_A_PLUS_B             = 4'd9;
   localparam logic [3:0] SEL_A_OR_NB_PLUS_A_AND_B = 4'd10;
   localparam logic [3:0] SEL_A_AND_B_MINUS_ONE    = 4'd11;
   localparam logic [3:0] SEL_A_PLUS_A             = 4'd12;
   localparam logic [3:0] SEL_A_OR_B_PLUS_A        = 4'd13;
   localparam logic [3:0] SEL_A_OR_NB_PLUS_A       = 4'd14;
   localparam logic [3:0] SEL_A_MINUS_ONE          = 4'd15;

   // Logic functions
   localparam logic [3:0] SEL_NOT_A       = 4'd0;
   localparam logic [3:0] SEL_NOR         = 4'd1;
   localparam logic [3:0] SEL_NOT_A_AND_B = 4'd2;
   localparam logic [3:0] SEL_ZERO        = 4'd3;
   localparam logic [3:0] SEL_NAND        = 4'd4;
   localparam logic [3:0] SEL_NOT_B       = 4'd5;
   localparam logic [3:0] SEL_XOR         = 4'd6;
   localparam logic [3:0] SEL_A_AND_NOT_B = 4'd7;
   localparam logic [3:0] SEL_NOT_A_OR_B  = 4'd8;
   localparam logic [3:0] SEL_XNOR        = 4'd9;
   localparam logic [3:0] SEL_PASS_B      = 4'd10;
   localparam logic [3:0] SEL_AND         = 4'd11;
   localparam logic [3:0] SEL_ONES        = 4'd12;
   localparam logic [3:0] SEL_A_OR_NOT_B  = 4'd13;
   localparam logic [3:0] SEL_OR          = 4'd14;
   localparam logic [3:0] SEL_PASS_A      = 4'd15;

   typedef struct packed {
      logic carry;
      logic zero;
      logic neg;
      logic ovf;
   } alu_flags_t;

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_core
// Description : Purely combinational WIDTH-bit ALU, 16 arithmetic and 16
//               logic functions with carry/zero/negative/overflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [3:0]       i_select,
   input  logic             i_mode,
   input  logic             i_cin,
   output logic [WIDTH-1:0] o_result,
   output alu_flags_t       o_flags
);

   localparam logic [WIDTH-1:0] C_ONES = '1;

   logic [WIDTH-1:0] w_x;
   logic [WIDTH-1:0] w_y;
   logic [WIDTH-1:0] w_logic;
   logic [WIDTH:0]   w_sum;

   // Adder operand pair and logic result for the selected function
   always_comb begin
      w_x     = i_a;
      w_y     = '0;
      w_logic = '0;
      case (i_select)
         SEL_INC_A:                begin w_x = i_a;          w_y = '0;          end
         SEL_INC_A_OR_B:           begin w_x = i_a | i_b;    w_y = '0;          end
         SEL_INC_A_OR_NB:          begin w_x = i_a | ~i_b;   w_y = '0;          end
         SEL_MINUS_ONE:            begin w_x = C_ONES;       w_y = '0;          end
         SEL_A_PLUS_A_AND_NB:      begin w_x = i_a;          w_y = i_a & ~i_b;  end
         SEL_A_OR_B_PLUS_A_AND_NB: begin w_x = i_a | i_b;    w_y = i_a & ~i_b;  end
         SEL_A_MINUS_B:            begin w_x = i_a;          w_y = ~i_b;        end
         SEL_A_AND_NB_MINUS_ONE:   begin w_x = i_a & ~i_b;   w_y = C_ONES;      end
         SEL_A_PLUS_A_AND_B:       begin w_x = i_a;          w_y = i_a & i_b;   end
         SEL_A_PLUS_B:             begin w_x = i_a;          w_y = i_b;         end
         SEL_A_OR_NB_PLUS_A_AND_B: begin w_x = i_a | ~i_b;   w_y = i_a & i_b;   end
         SEL_A_AND_B_MINUS_ONE:    begin w_x = i_a & i_b;    w_y = C_ONES;      end
         SEL_A_PLUS_A:             begin w_x = i_a;          w_y = i_a;         end
         SEL_A_OR_B_PLUS_A:        begin w_x = i_a | i_b;    w_y = i_a;         end
         SEL_A_OR_NB_PLUS_A:       begin w_x = i_a | ~i_b;   w_y = i_a;         end
         default:                  begin w_x = i_a;          w_y = C_ONES;      end
      endcase
      case (i_select)
         SEL_NOT_A:       w_logic = ~i_a;
         SEL_NOR:         w_logic = ~(i_a | i_b);
         SEL_NOT_A_AND_B: w_logic = ~i_a & i_b;
         SEL_ZERO:        w_logic = '0;
         SEL_NAND:        w_logic = ~(i_a & i_b);
         SEL_NOT_B:       w_logic = ~i_b;
         SEL_XOR:         w_logic = i_a ^ i_b;
         SEL_A_AND_NOT_B: w_logic = i_a & ~i_b;
         SEL_NOT_A_OR_B:  w_logic = ~i_a | i_b;
         SEL_XNOR:        w_logic = ~(i_a ^ i_b);
         SEL_PASS_B:      w_logic = i_b;
         SEL_AND:         w_logic = i_a & i_b;
         SEL_ONES:        w_logic = C_ONES;
         SEL_A_OR_NOT_B:  w_logic = i_a | ~i_b;
         SEL_OR:          w_logic = i_a | i_b;
         default:         w_logic = i_a;
      endcase
   end

   // Sum is one bit wider than the operands so bit WIDTH is the carry-out
   assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, i_cin};

   // Final result and flags; logic functions never carry or overflow
   always_comb begin
      o_result      = w_sum[WIDTH-1:0];
      o_flags.carry = w_sum[WIDTH];
      o_flags.ovf   = (w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]);
      if (i_mode == MODE_LOGIC) begin
         o_result      = w_logic;
         o_flags.carry = 1'b0;
         o_flags.ovf   = 1'b0;
      end
      o_flags.zero = (o_result == '0);
      o_flags.neg  = o_result[WIDTH-1];
   end

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe
// Description : Two-stage valid/ready pipelined ALU with accumulator and
//               stored carry for multi-word chaining.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [3:0]       in_select,
   input  logic             in_mode,
   input  logic             in_cin,
   input  logic             in_use_acc,
   input  logic             in_use_carry,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] alu_out,
   output logic             out_carry,
   output logic             out_zero,
   output logic             out_neg,
   output logic             out_ovf
);

   logic [WIDTH-1:0] r_acc;
   logic             r_carry;
   logic             r_s1_valid;
   logic [WIDTH-1:0] r_s1_result;
   alu_flags_t       r_s1_flags;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_result;
   alu_flags_t       r_out_flags;

   logic [WIDTH-1:0] w_a;
   logic             w_cin;
   logic [WIDTH-1:0] w_result;
   alu_flags_t       w_flags;
   logic             w_s2_adv;
   logic             w_s1_adv;
   logic             w_accept;

   assign w_a   = in_use_acc   ? r_acc   : in_a;
   assign w_cin = in_use_carry ? r_carry : in_cin;

   alu_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .i_a      (w_a),
      .i_b      (in_b),
      .i_select (in_select),
      .i_mode   (in_mode),
      .i_cin    (w_cin),
      .o_result (w_result),
      .o_flags  (w_flags)
   );

   // An empty output stage always advances, so stage 1 moves exactly when stage 2 does
   assign w_s2_adv = !r_out_valid || out_ready;
   assign w_s1_adv = w_s2_adv;
   assign in_ready = !r_s1_valid || w_s1_adv;
   assign w_accept = in_valid && in_ready;

   // Accumulator and stored carry follow every accepted op so the next op can chain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc   <= '0;
         r_carry <= 1'b0;
      end else if (w_accept) begin
         r_acc   <= w_result;
         r_carry <= w_flags.carry;
      end
   end

   // Stage 1 captures the result computed in the accept cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid  <= 1'b0;
         r_s1_result <= '0;
         r_s1_flags  <= '0;
      end else if (in_ready) begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1_result <= w_result;
            r_s1_flags  <= w_flags;
         end
      end
   end

   // Output stage holds its contents while the downstream stalls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid  <= 1'b0;
         r_out_result <= '0;
         r_out_flags  <= '0;
      end else if (w_s2_adv) begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_out_result <= r_s1_result;
            r_out_flags  <= r_s1_flags;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign alu_out   = r_out_result;
   assign out_carry = r_out_flags.carry;
   assign out_zero  = r_out_flags.zero;
   assign out_neg   = r_out_flags.neg;
   assign out_ovf   = r_out_flags.ovf;

endmodule
`default_nettype wire
